// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer.
// Holds the FSM state, control bundle and the run-mode control helper.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 4;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_freeze;
        logic ifid_freeze;
        logic idex_freeze;
        logic exmem_freeze;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    localparam ctrl_t CTRL_MEM_STALL = '{
        pc_freeze:    1'b1,
        ifid_freeze:  1'b1,
        idex_freeze:  1'b1,
        exmem_freeze: 1'b1,
        ifid_flush:   1'b0,
        idex_flush:   1'b0,
        memwb_flush:  1'b1
    };

    // Control when no memory stall is in force: branch beats RAW stall.
    function automatic ctrl_t run_ctrl(input logic branch, input logic raw);
        ctrl_t c;
        c = CTRL_NONE;
        if (branch) begin
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (raw) begin
            c.pc_freeze   = 1'b1;
            c.ifid_freeze = 1'b1;
            c.idex_flush  = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// RAW hazard compare between the ID sources and later-stage destinations.
// HAZARD_NO_FWD_EN widens the check to any EX/MEM writer (no forwarding).
module hazard_detect #(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src1_valid,
    input  logic                  id_src2_valid,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_wb_en,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    output logic                  raw_stall
);

    logic ex_hit;

    assign ex_hit = ex_wb_en &&
        ((id_src1_valid && (id_src1 == ex_dest)) ||
         (id_src2_valid && (id_src2 == ex_dest)));

`ifdef HAZARD_NO_FWD_EN
    logic mem_hit;
    logic unused_rd;

    assign mem_hit = mem_wb_en &&
        ((id_src1_valid && (id_src1 == mem_dest)) ||
         (id_src2_valid && (id_src2 == mem_dest)));
    assign unused_rd = ex_mem_read;
    assign raw_stall = ex_hit || mem_hit;
`else
    logic unused_mem;

    assign unused_mem = ^{mem_dest, mem_wb_en};
    assign raw_stall  = ex_mem_read && ex_hit;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with perf counters.
// Optional build macro: HAZARD_NO_FWD_EN (stall on any RAW, no forwarding).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src1_valid,
    input  logic                  id_src2_valid,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_wb_en,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_freeze,
    output logic                  ifid_freeze,
    output logic                  idex_freeze,
    output logic                  exmem_freeze,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  memwb_flush,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t            state;
    state_t            state_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nx;
    logic              timeout_set;
    logic              raw_stall;
    ctrl_t             ctrl;

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_src1_valid(id_src1_valid),
        .id_src2_valid(id_src2_valid),
        .ex_dest      (ex_dest),
        .ex_wb_en     (ex_wb_en),
        .ex_mem_read  (ex_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .raw_stall    (raw_stall)
    );

    // Next state, wait count and the freeze/flush set for this cycle.
    always_comb begin
        ctrl        = CTRL_NONE;
        state_nx    = state;
        wait_nx     = wait_cnt;
        timeout_set = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        ctrl     = CTRL_MEM_STALL;
                        state_nx = MEM_WAIT;
                        wait_nx  = WAIT_W'(1);
                    end else begin
                        ctrl = run_ctrl(ex_branch_taken, raw_stall);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        ctrl     = run_ctrl(ex_branch_taken, raw_stall);
                        state_nx = RUN;
                        wait_nx  = '0;
                    end else if (wait_cnt >= WAIT_MAX) begin
                        ctrl        = run_ctrl(ex_branch_taken, raw_stall);
                        state_nx    = RUN;
                        wait_nx     = '0;
                        timeout_set = 1'b1;
                    end else begin
                        ctrl    = CTRL_MEM_STALL;
                        wait_nx = wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state_nx = RUN;
                    wait_nx  = '0;
                end
            endcase
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Saturating stall/flush performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (ctrl.pc_freeze && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (ctrl.ifid_flush && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

    assign pc_freeze    = ctrl.pc_freeze;
    assign ifid_freeze  = ctrl.ifid_freeze;
    assign idex_freeze  = ctrl.idex_freeze;
    assign exmem_freeze = ctrl.exmem_freeze;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_flush   = ctrl.idex_flush;
    assign memwb_flush  = ctrl.memwb_flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table plus multi-cycle sequences.
// Expected control codes are {pc,ifid_fz,idex_fz,exmem_fz,ifid_fl,idex_fl,memwb_fl}.
module tb_hazard_ctrl;

    localparam int RW = 4;
    localparam int CW = 32;
    localparam int TMO = 8;

`ifdef HAZARD_NO_FWD_EN
    localparam bit NOFWD = 1'b1;
`else
    localparam bit NOFWD = 1'b0;
`endif

    localparam logic [6:0] E_NONE  = 7'b0000000;
    localparam logic [6:0] E_STALL = 7'b1100010;
    localparam logic [6:0] E_FLUSH = 7'b0000110;
    localparam logic [6:0] E_MEMS  = 7'b1111001;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_src1, id_src2;
    logic          id_src1_valid, id_src2_valid;
    logic [RW-1:0] ex_dest;
    logic          ex_wb_en, ex_mem_read;
    logic [RW-1:0] mem_dest;
    logic          mem_wb_en;
    logic          ex_branch_taken, mem_req, mem_ready;
    logic          pc_freeze, ifid_freeze, idex_freeze, exmem_freeze;
    logic          ifid_flush, idex_flush, memwb_flush;
    logic          mem_timeout;
    logic [CW-1:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [3:0] s1, s2;
        logic       v1, v2;
        logic [3:0] exd;
        logic       exwb, exrd;
        logic [3:0] memd;
        logic       memwb;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    hazard_ctrl #(
        .REG_ADDR_W (RW),
        .CNT_W      (CW),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_src1        (id_src1),
        .id_src2        (id_src2),
        .id_src1_valid  (id_src1_valid),
        .id_src2_valid  (id_src2_valid),
        .ex_dest        (ex_dest),
        .ex_wb_en       (ex_wb_en),
        .ex_mem_read    (ex_mem_read),
        .mem_dest       (mem_dest),
        .mem_wb_en      (mem_wb_en),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_freeze      (pc_freeze),
        .ifid_freeze    (ifid_freeze),
        .idex_freeze    (idex_freeze),
        .exmem_freeze   (exmem_freeze),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .memwb_flush    (memwb_flush),
        .mem_timeout    (mem_timeout),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    always #5 clk = ~clk;

    task automatic check_ctrl(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {pc_freeze, ifid_freeze, idex_freeze, exmem_freeze,
               ifid_flush, idex_flush, memwb_flush};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: ctrl got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        id_src1 = '0; id_src2 = '0;
        id_src1_valid = 0; id_src2_valid = 0;
        ex_dest = '0; ex_wb_en = 0; ex_mem_read = 0;
        mem_dest = '0; mem_wb_en = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_loaduse(input logic [3:0] r);
        ex_mem_read = 1; ex_wb_en = 1; ex_dest = r;
        id_src2 = r; id_src2_valid = 1;
    endtask

    initial begin
        vecs[0] = '{"none",      1, 2, 1, 1, 3, 1, 1, 4, 1, 0, E_NONE};
        vecs[1] = '{"lu_src2",   1, 3, 1, 1, 3, 1, 1, 0, 0, 0, E_STALL};
        vecs[2] = '{"lu_src1",   9, 2, 1, 1, 9, 1, 1, 0, 0, 0, E_STALL};
        vecs[3] = '{"lu_inval",  9, 9, 0, 0, 9, 1, 1, 0, 0, 0, E_NONE};
        vecs[4] = '{"ld_nowb",   6, 2, 1, 1, 6, 0, 1, 0, 0, 0, E_NONE};
        vecs[5] = '{"alu_ex",    6, 2, 1, 1, 6, 1, 0, 0, 0, 0,
                    NOFWD ? E_STALL : E_NONE};
        vecs[6] = '{"br_lu",     5, 1, 1, 1, 5, 1, 1, 0, 0, 1, E_FLUSH};
        vecs[7] = '{"br_only",   1, 2, 1, 1, 3, 0, 0, 0, 0, 1, E_FLUSH};
        vecs[8] = '{"mem_raw",   7, 2, 1, 0, 0, 0, 0, 7, 1, 0,
                    NOFWD ? E_STALL : E_NONE};
        vecs[9] = '{"mem_nowb",  7, 2, 1, 0, 0, 0, 0, 7, 0, 0, E_NONE};

        rst = 1'b1;
        idle_inputs();
        set_loaduse(4'd3);
        ex_branch_taken = 1;
        #2;
        check_ctrl("rst_outputs", E_NONE);
        check_val("rst_stall_cnt", stall_cycles, 0);
        check_val("rst_flush_cnt", flush_events, 0);
        check_val("rst_timeout", {31'b0, mem_timeout}, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            id_src1 = vecs[i].s1; id_src2 = vecs[i].s2;
            id_src1_valid = vecs[i].v1; id_src2_valid = vecs[i].v2;
            ex_dest = vecs[i].exd; ex_wb_en = vecs[i].exwb;
            ex_mem_read = vecs[i].exrd;
            mem_dest = vecs[i].memd; mem_wb_en = vecs[i].memwb;
            ex_branch_taken = vecs[i].br;
            mem_req = 0; mem_ready = 0;
            #1;
            check_ctrl(vecs[i].name, vecs[i].exp);
        end

        // Load-use: one stall, then the EX bubble clears it.
        do_reset();
        set_loaduse(4'd3);
        #1 check_ctrl("lu_stall", E_STALL);
        @(negedge clk);
        ex_mem_read = 0; ex_wb_en = 0;
        #1 check_ctrl("lu_bubble", E_NONE);
        check_val("lu_stall_cnt", stall_cycles, 1);
        check_val("lu_flush_cnt", flush_events, 0);

        // Branch wins over load-use in the same cycle.
        do_reset();
        set_loaduse(4'd5);
        ex_branch_taken = 1;
        #1 check_ctrl("br_vs_lu", E_FLUSH);
        @(negedge clk);
        idle_inputs();
        #1 check_val("br_flush_cnt", flush_events, 1);
        check_val("br_stall_cnt", stall_cycles, 0);

        // Memory wait 4 cycles, branch held in EX from cycle 1.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            mem_req = 1;
            mem_ready = (k == 4);
            ex_branch_taken = (k >= 1);
            #1 check_ctrl($sformatf("mw_cyc%0d", k),
                          (k == 4) ? E_FLUSH : E_MEMS);
            @(negedge clk);
        end
        idle_inputs();
        #1 check_ctrl("mw_run", E_NONE);
        check_val("mw_stall_cnt", stall_cycles, 4);
        check_val("mw_flush_cnt", flush_events, 1);

        // Single-cycle access never stalls.
        @(negedge clk);
        mem_req = 1; mem_ready = 1;
        #1 check_ctrl("mem_1cyc", E_NONE);
        @(negedge clk);
        idle_inputs();

        // Timeout: ready never comes.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int k = 0; k < TMO; k++) begin
            #1 check_ctrl($sformatf("to_cyc%0d", k), E_MEMS);
            @(negedge clk);
        end
        #1 check_ctrl("to_release", E_NONE);
        check_val("to_flag_pre", {31'b0, mem_timeout}, 0);
        @(negedge clk);
        mem_req = 0;
        #1 check_val("to_flag", {31'b0, mem_timeout}, 1);
        check_val("to_stall_cnt", stall_cycles, TMO);
        check_ctrl("to_run", E_NONE);
        repeat (3) @(negedge clk);
        check_val("to_sticky", {31'b0, mem_timeout}, 1);
        do_reset();
        #1 check_val("to_cleared", {31'b0, mem_timeout}, 0);

        // Asynchronous reset on the second MEM_WAIT cycle.
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (2) @(negedge clk);
        #1 check_ctrl("rw_wait", E_MEMS);
        #2 rst = 1'b1;
        #1 check_ctrl("rw_rst_out", E_NONE);
        check_val("rw_rst_cnt", stall_cycles, 0);
        @(negedge clk);
        mem_req = 0;
        rst = 1'b0;
        #1 check_ctrl("rw_after", E_NONE);
        @(negedge clk);
        #1 check_ctrl("rw_run", E_NONE);
        check_val("rw_stall_cnt", stall_cycles, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
